// File: rtl/cm0_wic_ctl.sv
// -----------------------------------------------------------------------------
// cm0_wic_ctl -- Wake-up Interrupt Controller control block.
//
// The NVIC hands a sensitivity mask to this block before the core is
// power-gated. While armed, masked wake lines are latched into sticky pending
// bits, and the first masked event raises a wake request to the power
// controller.
//
// Parameters
//   WICLINES  number of wake lines (3..64): bit0 NMI, bit1 RXEV, bits 2+ IRQs
//   SYNC_IN   1: wic_int_i passes through one register stage before use
//             0: wic_int_i is sampled directly
//
// Ports
//   hclk            sole clock, rising edge
//   hreset_n        synchronous active-low reset
//   wic_ds_req_n_i  WIC mode request from power controller (active-low)
//   wic_ds_ack_n_o  WIC mode acknowledge (active-low)
//   wic_load_i      pulse: upload sensitivity mask from wic_mask_i
//   wic_clear_i     pulse: clear mask and pending state
//   wic_mask_i      sensitivity mask, sampled only on a load
//   wic_int_i       raw wake lines, level-high
//   wic_pend_o      latched pending wake sources
//   wic_en_o        high while armed (ARMED or WAKE)
//   wakeup_o        wake request to the power controller (WAKE only)
//   dbg_state_o     current FSM state, for observation only
//
// Handshake: wic_ds_req_n_i low asks for WIC mode; wic_ds_ack_n_o follows it
// one edge later (low in ENABLED/ARMED/WAKE, high in DISABLED). Releasing the
// request wins over every other event in the same cycle.
// -----------------------------------------------------------------------------
module cm0_wic_ctl #(
    parameter int WICLINES = 34,
    parameter bit SYNC_IN  = 1'b0
) (
    input  logic                hclk,
    input  logic                hreset_n,
    input  logic                wic_ds_req_n_i,
    output logic                wic_ds_ack_n_o,
    input  logic                wic_load_i,
    input  logic                wic_clear_i,
    input  logic [WICLINES-1:0] wic_mask_i,
    input  logic [WICLINES-1:0] wic_int_i,
    output logic [WICLINES-1:0] wic_pend_o,
    output logic                wic_en_o,
    output logic                wakeup_o,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ENABLED  = 2'd1,
        ST_ARMED    = 2'd2,
        ST_WAKE     = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [WICLINES-1:0] mask, mask_nxt;
    logic [WICLINES-1:0] pend, pend_nxt;
    logic [WICLINES-1:0] int_s;
    logic [WICLINES-1:0] hit;

    // Optional input staging: adds one cycle of wake latency.
    generate
        if (SYNC_IN) begin : g_sync
            logic [WICLINES-1:0] int_q;
            always_ff @(posedge hclk) begin
                if (!hreset_n) begin
                    int_q <= '0;
                end else begin
                    int_q <= wic_int_i;
                end
            end
            assign int_s = int_q;
        end else begin : g_direct
            assign int_s = wic_int_i;
        end
    endgenerate

    assign hit = int_s & mask;

    // Next-state logic. Within a cycle: request release > clear > load > capture.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        pend_nxt  = pend;
        unique case (state)
            ST_DISABLED: begin
                if (!wic_ds_req_n_i) begin
                    state_nxt = ST_ENABLED;
                end
            end
            ST_ENABLED: begin
                if (wic_ds_req_n_i) begin
                    state_nxt = ST_DISABLED;
                end else if (wic_clear_i) begin
                    // Clear is a no-op here, but it still blocks a
                    // simultaneous load.
                    state_nxt = ST_ENABLED;
                end else if (wic_load_i) begin
                    state_nxt = ST_ARMED;
                    mask_nxt  = wic_mask_i;
                    pend_nxt  = '0;
                end
            end
            ST_ARMED, ST_WAKE: begin
                if (wic_ds_req_n_i) begin
                    state_nxt = ST_DISABLED;
                    mask_nxt  = '0;
                    pend_nxt  = '0;
                end else if (wic_clear_i) begin
                    state_nxt = ST_ENABLED;
                    mask_nxt  = '0;
                    pend_nxt  = '0;
                end else begin
                    // Loads are ignored once armed; only capture proceeds.
                    pend_nxt = pend | hit;
                    if (|hit) begin
                        state_nxt = ST_WAKE;
                    end
                end
            end
            default: begin
                state_nxt = ST_DISABLED;
                mask_nxt  = '0;
                pend_nxt  = '0;
            end
        endcase
    end

    // State, mask, pend and the registered status outputs. The outputs are
    // decoded from the next state so they line up with the state register.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state          <= ST_DISABLED;
            mask           <= '0;
            pend           <= '0;
            wic_ds_ack_n_o <= 1'b1;
            wic_en_o       <= 1'b0;
            wakeup_o       <= 1'b0;
        end else begin
            state          <= state_nxt;
            mask           <= mask_nxt;
            pend           <= pend_nxt;
            wic_ds_ack_n_o <= (state_nxt == ST_DISABLED);
            wic_en_o       <= (state_nxt == ST_ARMED) || (state_nxt == ST_WAKE);
            wakeup_o       <= (state_nxt == ST_WAKE);
        end
    end

    assign wic_pend_o  = pend;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_cm0_wic_ctl.sv
// -----------------------------------------------------------------------------
// tb_cm0_wic_ctl -- directed bench for cm0_wic_ctl (WICLINES=34).
// Two instances share all inputs: dut0 samples wake lines directly, dut1 has
// the extra input stage. The vector table and most sequences check dut0; the
// latency sequence compares both.
// -----------------------------------------------------------------------------
module tb_cm0_wic_ctl;

  localparam int WL = 34;

  logic          hclk;
  logic          hreset_n;
  logic          req_n;
  logic          load;
  logic          clr;
  logic [WL-1:0] mask;
  logic [WL-1:0] ints;

  logic          ack_n0, en0, wake0;
  logic [WL-1:0] pend0;
  logic [1:0]    dbg0;
  logic          ack_n1, en1, wake1;
  logic [WL-1:0] pend1;
  logic [1:0]    dbg1;

  int checks = 0;
  int errors = 0;

  cm0_wic_ctl #(.WICLINES(WL), .SYNC_IN(1'b0)) dut0 (
    .hclk(hclk), .hreset_n(hreset_n),
    .wic_ds_req_n_i(req_n), .wic_ds_ack_n_o(ack_n0),
    .wic_load_i(load), .wic_clear_i(clr),
    .wic_mask_i(mask), .wic_int_i(ints),
    .wic_pend_o(pend0), .wic_en_o(en0), .wakeup_o(wake0),
    .dbg_state_o(dbg0)
  );

  cm0_wic_ctl #(.WICLINES(WL), .SYNC_IN(1'b1)) dut1 (
    .hclk(hclk), .hreset_n(hreset_n),
    .wic_ds_req_n_i(req_n), .wic_ds_ack_n_o(ack_n1),
    .wic_load_i(load), .wic_clear_i(clr),
    .wic_mask_i(mask), .wic_int_i(ints),
    .wic_pend_o(pend1), .wic_en_o(en1), .wakeup_o(wake1),
    .dbg_state_o(dbg1)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        req_n;
    logic        load;
    logic        clr;
    logic [63:0] mask;
    logic [63:0] ints;
    logic        exp_ack_n;
    logic        exp_en;
    logic        exp_wake;
    logic [63:0] exp_pend;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic ld, input logic c,
                     input logic [63:0] m, input logic [63:0] i,
                     input logic a, input logic e, input logic w,
                     input logic [63:0] p);
    vec_t v;
    v.req_n = r; v.load = ld; v.clr = c; v.mask = m; v.ints = i;
    v.exp_ack_n = a; v.exp_en = e; v.exp_wake = w; v.exp_pend = p;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs on the falling edge, then sample #1 after the rise
  task automatic drive(input logic r, input logic ld, input logic c,
                       input logic [WL-1:0] m, input logic [WL-1:0] i);
    @(negedge hclk);
    req_n = r; load = ld; clr = c; mask = m; ints = i;
    @(posedge hclk);
    #1;
  endtask

  task automatic check0(input string tag, input logic a, input logic e,
                        input logic w, input logic [63:0] p);
    check({tag, ".ack_n"}, 64'(ack_n0), 64'(a));
    check({tag, ".en"},    64'(en0),    64'(e));
    check({tag, ".wake"},  64'(wake0),  64'(w));
    check({tag, ".pend"},  64'(pend0),  p);
  endtask

  initial begin
    hreset_n = 1'b0;
    req_n = 1'b1; load = 1'b0; clr = 1'b0; mask = '0; ints = '0;

    // reset state
    drive(1'b0, 1'b1, 1'b0, '1, '1);
    drive(1'b0, 1'b1, 1'b1, '1, '1);
    check0("reset0", 1'b1, 1'b0, 1'b0, 64'h0);
    check({"reset1", ".ack_n"}, 64'(ack_n1), 64'h1);
    check({"reset1", ".pend"},  64'(pend1),  64'h0);
    @(negedge hclk);
    hreset_n = 1'b1;

    //   req ld clr mask            int              ack en wk pend
    add(1, 0, 0, 64'h0,           64'h0,           1, 0, 0, 64'h0); // idle DISABLED
    add(0, 1, 0, 64'h4,           64'h0,           0, 0, 0, 64'h0); // request; load ignored
    add(0, 0, 0, 64'h0,           64'h4,           0, 0, 0, 64'h0); // ENABLED ignores lines
    add(1, 0, 0, 64'h0,           64'h0,           1, 0, 0, 64'h0); // release -> DISABLED
    add(0, 0, 0, 64'h0,           64'h0,           0, 0, 0, 64'h0);
    add(0, 1, 0, 64'h4,           64'h0,           0, 1, 0, 64'h0); // arm, mask IRQ0
    add(0, 1, 0, 64'h1,           64'h0,           0, 1, 0, 64'h0); // load while armed ignored
    add(0, 0, 0, 64'h0,           64'h1,           0, 1, 0, 64'h0); // NMI still unmasked
    add(0, 0, 0, 64'h0,           64'h4,           0, 1, 1, 64'h4); // wake
    add(0, 0, 0, 64'h0,           64'h0,           0, 1, 1, 64'h4); // sticky
    add(0, 0, 0, 64'h0,           64'h3FFFFFFFF,   0, 1, 1, 64'h4); // unmasked in WAKE
    add(0, 0, 1, 64'h0,           64'h0,           0, 0, 0, 64'h0); // clear -> ENABLED
    add(0, 1, 1, 64'h4,           64'h4,           0, 0, 0, 64'h0); // load+clear: stays ENABLED
    add(0, 0, 0, 64'h0,           64'h4,           0, 0, 0, 64'h0);
    add(0, 1, 0, 64'h0,           64'h0,           0, 1, 0, 64'h0); // zero mask arms
    add(0, 0, 0, 64'h0,           64'h3FFFFFFFF,   0, 1, 0, 64'h0); // never wakes
    add(0, 0, 1, 64'h0,           64'h0,           0, 0, 0, 64'h0);
    add(0, 1, 0, 64'h1,           64'h0,           0, 1, 0, 64'h0); // mask NMI
    add(0, 0, 0, 64'h0,           64'h3FFFFFFFE,   0, 1, 0, 64'h0);
    add(0, 0, 0, 64'h0,           64'h3FFFFFFFF,   0, 1, 1, 64'h1);
    add(0, 0, 0, 64'h0,           64'h0,           0, 1, 1, 64'h1);
    add(1, 0, 1, 64'h0,           64'h0,           1, 0, 0, 64'h0); // release+clear in WAKE
    add(0, 0, 0, 64'h0,           64'h0,           0, 0, 0, 64'h0);
    add(0, 1, 0, 64'h5,           64'h0,           0, 1, 0, 64'h0);
    add(1, 0, 1, 64'h0,           64'h5,           1, 0, 0, 64'h0); // release+clear in ARMED
    add(0, 0, 0, 64'h0,           64'h0,           0, 0, 0, 64'h0);
    add(0, 1, 0, 64'h5,           64'h0,           0, 1, 0, 64'h0);
    add(0, 0, 0, 64'h0,           64'h1,           0, 1, 1, 64'h1);
    add(0, 0, 0, 64'h0,           64'h4,           0, 1, 1, 64'h5); // OR-in while in WAKE

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].req_n, vq[k].load, vq[k].clr, vq[k].mask[WL-1:0], vq[k].ints[WL-1:0]);
      check0($sformatf("vec%0d", k), vq[k].exp_ack_n, vq[k].exp_en,
             vq[k].exp_wake, vq[k].exp_pend);
    end

    // reset while in WAKE with pend=0x5, inputs arbitrary during reset
    @(negedge hclk);
    hreset_n = 1'b0;
    req_n = 1'($urandom_range(0, 1));
    load = 1'($urandom_range(0, 1));
    clr = 1'b0;
    ints = '1;
    @(posedge hclk);
    #1;
    check0("rst_wake", 1'b1, 1'b0, 1'b0, 64'h0);
    @(negedge hclk);
    hreset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, '0, '1);
      check0($sformatf("post_rst%0d", k), 1'b1, 1'b0, 1'b0, 64'h0);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check0("rereq", 1'b0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b1, 1'b0, WL'(5), '0);
    check0("rearm", 1'b0, 1'b1, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check0("rearm_idle", 1'b0, 1'b1, 1'b0, 64'h0);

    // single-cycle IRQ0 pulse; dut1 lags dut0 by one edge
    @(negedge hclk);
    hreset_n = 1'b0;
    @(negedge hclk);
    hreset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, WL'(4), '0);
    check("sync1.en_armed", 64'(en1), 64'h1);
    drive(1'b0, 1'b0, 1'b0, '0, WL'(4));
    check0("pulse", 1'b0, 1'b1, 1'b1, 64'h4);
    check("sync1.pend_edge_n", 64'(pend1), 64'h0);
    check("sync1.wake_edge_n", 64'(wake1), 64'h0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check("sync1.pend_edge_n1", 64'(pend1), 64'h4);
    check("sync1.wake_edge_n1", 64'(wake1), 64'h1);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
    end
    check0("pulse_10", 1'b0, 1'b1, 1'b1, 64'h4);
    check("sync1.pend_10", 64'(pend1), 64'h4);

    // request release handshake on both instances
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    check0("release", 1'b1, 1'b0, 1'b0, 64'h0);
    check("sync1.ack_release", 64'(ack_n1), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
